// File: rtl/fir_resampler_pkg.sv
// Shared types and derived constants for the FIR resampler reconfiguration controller.
package fir_resampler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   // Zero samples needed to push old history out of every polyphase branch.
   // Clamped to one so a degenerate configuration still exercises the flush path.
   function automatic int unsigned flush_samples(input int unsigned order,
                                                 input int unsigned interp);
      int unsigned n;
      n = order / interp;
      return (n == 0) ? 32'd1 : n;
   endfunction

endpackage

// File: rtl/fir_resampler_coef_fetch.sv
// Coefficient store walker: ascending read addresses and one-cycle aligned
// write strobes towards the resampler coefficient RAM.
module fir_resampler_coef_fetch #(
   parameter int unsigned FILTER_ORDER = 256,
   parameter int unsigned COEF_WIDTH   = 16,
   parameter int unsigned COEF_AWIDTH  = $clog2(FILTER_ORDER)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   output logic                   src_rd_o,
   output logic [COEF_AWIDTH-1:0] src_addr_o,
   input  logic [COEF_WIDTH-1:0]  src_data_i,
   output logic                   coef_we_o,
   output logic [COEF_AWIDTH-1:0] coef_addr_o,
   output logic [COEF_WIDTH-1:0]  coef_data_o,
   output logic                   wr_last_o
);

   localparam logic [COEF_AWIDTH-1:0] LAST_ADDR = COEF_AWIDTH'(FILTER_ORDER - 1);

   logic                   rd_q,    rd_d;
   logic [COEF_AWIDTH-1:0] addr_q,  addr_d;
   logic                   we_q,    we_d;
   logic [COEF_AWIDTH-1:0] waddr_q, waddr_d;
   logic                   last_q,  last_d;

   // Read sequencing; terminal address found by compare, the counter never wraps.
   always_comb begin
      rd_d    = 1'b0;
      addr_d  = addr_q;
      we_d    = rd_q;
      waddr_d = addr_q;
      last_d  = rd_q && (addr_q == LAST_ADDR);
      if (start_i) begin
         rd_d   = 1'b1;
         addr_d = '0;
      end else if (rd_q && (addr_q != LAST_ADDR)) begin
         rd_d   = 1'b1;
         addr_d = addr_q + COEF_AWIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q    <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         last_q  <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         last_q  <= last_d;
      end
   end

   assign src_rd_o    = rd_q;
   assign src_addr_o  = addr_q;
   assign coef_we_o   = we_q;
   assign coef_addr_o = waddr_q;
   // Store data arrives the cycle after the read, exactly when the write strobe is up.
   assign coef_data_o = src_data_i;
   assign wr_last_o   = last_q;

endmodule

// File: rtl/fir_resampler_reconf_ctrl.sv
// Reconfiguration controller for a polyphase FIR resampler: drains in-flight
// results, reloads the coefficients from a store, then flushes history with zeros.
module fir_resampler_reconf_ctrl
   import fir_resampler_pkg::*;
#(
   parameter int unsigned FILTER_ORDER  = 256,
   parameter int unsigned INTERPOLATION = 32,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned COEF_WIDTH    = 16,
   parameter int unsigned DRAIN_CYCLES  = 64,
   parameter int unsigned FLUSH_GAP     = 32,
   parameter int unsigned COEF_AWIDTH   = $clog2(FILTER_ORDER)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          reconfig_req_i,
   output logic                          src_rd_o,
   output logic [COEF_AWIDTH-1:0]        src_addr_o,
   input  logic [COEF_WIDTH-1:0]         src_data_i,
   input  logic signed [DATA_WIDTH-1:0]  data_i,
   input  logic                          data_val_i,
   output logic                          data_ready_o,
   output logic signed [DATA_WIDTH-1:0]  data_o,
   output logic                          data_val_o,
   output logic                          coef_we_o,
   output logic [COEF_AWIDTH-1:0]        coef_addr_o,
   output logic [COEF_WIDTH-1:0]         coef_data_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          req_err_o
);

   localparam int unsigned FLUSH_SAMPLES = flush_samples(FILTER_ORDER, INTERPOLATION);
   localparam int unsigned CNT_MAX       = (DRAIN_CYCLES > FLUSH_GAP) ? DRAIN_CYCLES : FLUSH_GAP;
   localparam int unsigned CNT_W         = $clog2(CNT_MAX + 1);
   localparam int unsigned SMP_W         = $clog2(FLUSH_SAMPLES + 1);

   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(FLUSH_GAP - 1);
   localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'(FLUSH_SAMPLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [SMP_W-1:0]   smp_q,   smp_d;
   logic               stb_q,   stb_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic               err_q,   err_d;
   logic               fetch_start_c;
   logic               fetch_last;
   logic               idle_c;

   fir_resampler_coef_fetch #(
      .FILTER_ORDER (FILTER_ORDER),
      .COEF_WIDTH   (COEF_WIDTH),
      .COEF_AWIDTH  (COEF_AWIDTH)
   ) u_fetch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (fetch_start_c),
      .src_rd_o    (src_rd_o),
      .src_addr_o  (src_addr_o),
      .src_data_i  (src_data_i),
      .coef_we_o   (coef_we_o),
      .coef_addr_o (coef_addr_o),
      .coef_data_o (coef_data_o),
      .wr_last_o   (fetch_last)
   );

   // Next state, counters and next values of the registered status outputs.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      smp_d         = smp_q;
      stb_d         = 1'b0;
      fetch_start_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (reconfig_req_i) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d       = ST_LOAD;
               fetch_start_c = 1'b1;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LOAD: begin
            if (fetch_last) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
               smp_d   = '0;
               stb_d   = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == GAP_LAST) begin
               if (smp_q == SMP_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = '0;
                  smp_d = smp_q + SMP_W'(1);
                  stb_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      // Flag the upcoming final FLUSH cycle so done lands inside it.
      done_d = (state_d == ST_FLUSH) && (smp_d == SMP_LAST) && (cnt_d == GAP_LAST);
      err_d  = reconfig_req_i && (state_q != ST_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         smp_q   <= '0;
         stb_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         smp_q   <= smp_d;
         stb_q   <= stb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Upstream passes straight through only while idle; otherwise only zero strobes.
   assign idle_c       = (state_q == ST_IDLE);
   assign data_ready_o = idle_c;
   assign data_o       = idle_c ? data_i : '0;
   assign data_val_o   = idle_c ? data_val_i : stb_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign req_err_o    = err_q;

endmodule

// File: tb/tb_fir_resampler_reconf_ctrl.sv
// Randomized bench for fir_resampler_reconf_ctrl against a cycle-offset model
// of the reconfiguration sequence.
module tb_fir_resampler_reconf_ctrl;

   localparam int unsigned ORD    = 16;
   localparam int unsigned INTERP = 4;
   localparam int unsigned DRAIN  = 8;
   localparam int unsigned GAP    = 4;
   localparam int unsigned DW     = 16;
   localparam int unsigned CW     = 16;
   localparam int unsigned AW     = 4;
   localparam int unsigned NSMP   = ORD / INTERP;

   // Cycle offsets counted from the accepted request (request cycle = 0).
   localparam int K_LOAD  = DRAIN + 1;
   localparam int K_FLUSH = K_LOAD + ORD + 1;
   localparam int K_END   = K_FLUSH + NSMP * GAP - 1;

   logic          clk_i;
   logic          rst_i;
   logic          reconfig_req_i;
   logic          src_rd_o;
   logic [AW-1:0] src_addr_o;
   logic [CW-1:0] src_data_i;
   logic [DW-1:0] data_i;
   logic          data_val_i;
   logic          data_ready_o;
   logic [DW-1:0] data_o;
   logic          data_val_o;
   logic          coef_we_o;
   logic [AW-1:0] coef_addr_o;
   logic [CW-1:0] coef_data_o;
   logic          busy_o;
   logic          done_o;
   logic          req_err_o;

   fir_resampler_reconf_ctrl #(
      .FILTER_ORDER  (ORD),
      .INTERPOLATION (INTERP),
      .DATA_WIDTH    (DW),
      .COEF_WIDTH    (CW),
      .DRAIN_CYCLES  (DRAIN),
      .FLUSH_GAP     (GAP),
      .COEF_AWIDTH   (AW)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .reconfig_req_i (reconfig_req_i),
      .src_rd_o       (src_rd_o),
      .src_addr_o     (src_addr_o),
      .src_data_i     (src_data_i),
      .data_i         (data_i),
      .data_val_i     (data_val_i),
      .data_ready_o   (data_ready_o),
      .data_o         (data_o),
      .data_val_o     (data_val_o),
      .coef_we_o      (coef_we_o),
      .coef_addr_o    (coef_addr_o),
      .coef_data_o    (coef_data_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .req_err_o      (req_err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int            n_vec;
   int            n_err;
   logic [CW-1:0] mem [ORD];
   bit            active;
   int            k;
   bit            err_exp;
   bit            store_rd;
   logic [AW-1:0] store_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t, k=%0d)", tag, got, exp, $time, k);
      end
   endtask

   task automatic fill_mem();
      for (int i = 0; i < int'(ORD); i++) mem[i] = CW'($urandom);
   endtask

   // Expected outputs follow directly from the offset k into the sequence.
   task automatic check_cycle(input logic [DW-1:0] din, input logic dval);
      bit idle, rd_e, we_e, stb_e, done_e;
      idle   = !active;
      rd_e   = active && (k >= K_LOAD) && (k < K_LOAD + int'(ORD));
      we_e   = active && (k > K_LOAD) && (k <= K_LOAD + int'(ORD));
      stb_e  = active && (k >= K_FLUSH) && (((k - K_FLUSH) % int'(GAP)) == 0);
      done_e = active && (k == K_END);
      chk("busy",    32'(busy_o),       32'(active));
      chk("ready",   32'(data_ready_o), 32'(idle));
      chk("dval",    32'(data_val_o),   idle ? 32'(dval) : 32'(stb_e));
      chk("data",    32'(data_o),       idle ? 32'(din) : 32'd0);
      chk("src_rd",  32'(src_rd_o),     32'(rd_e));
      if (rd_e) chk("src_addr", 32'(src_addr_o), 32'(k - K_LOAD));
      chk("coef_we", 32'(coef_we_o),    32'(we_e));
      if (we_e) begin
         chk("coef_addr", 32'(coef_addr_o), 32'(k - K_LOAD - 1));
         chk("coef_data", 32'(coef_data_o), 32'(mem[k - K_LOAD - 1]));
      end
      chk("done",    32'(done_o),       32'(done_e));
      chk("req_err", 32'(req_err_o),    32'(err_exp));
   endtask

   // One clock cycle: drive, check mid-cycle, advance the model, cross the edge.
   task automatic step(input bit req, input bit dval, input logic [DW-1:0] din);
      bit nerr;
      reconfig_req_i = req;
      data_val_i     = dval;
      data_i         = din;
      src_data_i     = store_rd ? mem[store_addr] : CW'($urandom);
      #1;
      check_cycle(din, dval);
      store_rd   = src_rd_o;
      store_addr = src_addr_o;
      nerr = req && active;
      if (active) begin
         k++;
         if (k > K_END) active = 1'b0;
      end else if (req) begin
         active = 1'b1;
         k      = 1;
      end
      err_exp = nerr;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      active = 1'b0; k = 0; err_exp = 1'b0;
      store_rd = 1'b0; store_addr = '0;
      rst_i = 1'b1; reconfig_req_i = 1'b0;
      data_val_i = 1'b0; data_i = '0; src_data_i = '0;
      fill_mem();

      #2;
      check_cycle('0, 1'b0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // idle pass-through
      step(1'b0, 1'b1, 16'h1234);
      for (int i = 0; i < 6; i++) step(1'b0, 1'($urandom), DW'($urandom));

      // full reconfig, request with a coincident sample, upstream valid throughout
      fill_mem();
      step(1'b1, 1'b1, DW'($urandom));
      for (int i = 1; i <= K_END + 3; i++) step(1'b0, 1'b1, DW'($urandom));

      // extra requests during LOAD and in the final FLUSH cycle
      fill_mem();
      step(1'b1, 1'b0, '0);
      for (int i = 1; i <= K_END; i++)
         step((i == K_LOAD + 3) || (i == K_END), 1'($urandom), DW'($urandom));
      for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), DW'($urandom));

      // asynchronous reset right after coefficient address 5 is written
      fill_mem();
      step(1'b1, 1'b0, '0);
      for (int i = 1; i <= K_LOAD + 6; i++) step(1'b0, 1'($urandom), DW'($urandom));
      rst_i    = 1'b1;
      active   = 1'b0;
      err_exp  = 1'b0;
      store_rd = 1'b0;
      #1;
      check_cycle(data_i, data_val_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom), DW'($urandom));

      // complete reload after the aborted one
      fill_mem();
      step(1'b1, 1'b1, DW'($urandom));
      for (int i = 1; i <= K_END + 2; i++) step(1'b0, 1'($urandom), DW'($urandom));

      // random traffic with sparse requests
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 19) == 0, 1'($urandom), DW'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
